map_port_arbiter: RTL and testbench
===================================

# map_port_arbiter

Arbitrates the single-port 10×20 map RAM between three requesters: the VGA sprite renderer, the robot sensor/update logic, and the cursor editor. It sits between those blocks and the map RAM inside `world`. It converts 1-based row/column requests to linear RAM addresses and issues at most one access per clock. It grants by fixed priority, with optional anti-starvation promotion, and returns read data with fixed latency.

## Interface
Parameters:
- `ROWS`, 10, map rows (valid rows 1..ROWS)
- `COLS`, 20, map columns (valid columns 1..COLS)
- `ROW_W`, 4, row index width
- `COL_W`, 5, column index width
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 4, cell (sprite code) width
- `STARVE_MAX`, 15, wait-cycle threshold for promotion

Ports:
- `clock_50`  in  1  system clock
- `reset_key`  in  1  reset, asynchronous, active-low
- `vga_req`, `rob_req`, `cur_req`  in  1 each  access requests
- `vga_row`/`rob_row`/`cur_row`  in  ROW_W  requested row
- `vga_col`/`rob_col`/`cur_col`  in  COL_W  requested column
- `cur_we`  in  1  cursor write (1) or read (0)
- `cur_wdata`  in  DATA_W  cursor write data
- `vga_gnt`, `rob_gnt`, `cur_gnt`  out  1 each  grant pulse
- `vga_rvalid`, `rob_rvalid`, `cur_rvalid`  out  1 each  read-data valid pulse
- `rdata`  out  DATA_W  shared read data, qualified by the rvalid lines
- `addr_err`  out  1  out-of-range request pulse
- `mem_en`, `mem_we`  out  1 each  RAM enable and write strobe
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after `mem_en`

## Operation
- Address mapping: `mem_addr = (row-1)*COLS + (col-1)`. For example, row 1/col 1 maps to 0, and row 10/col 20 maps to 199.
- Eligibility:
  - A requester is eligible when its req is high and its gnt is not high in that cycle.
  - A requester must hold req, row, col, we and wdata stable until gnt.
  - A requester must drop req in the gnt cycle or it will be granted again.
- Priority: VGA > robot > cursor. At most one grant per cycle.
- Anti-starvation (macro-controlled):
  - Robot and cursor each have a wait counter.
  - The counter increments every cycle the requester is eligible but not selected, saturating at STARVE_MAX.
  - The counter clears on grant.
  - A requester whose counter equals STARVE_MAX outranks VGA. If both are promoted, robot wins.
- Out-of-range requests (row 0, row > ROWS, col 0, col > COLS):
  - The request is still granted and `addr_err` pulses with the gnt.
  - `mem_en` stays 0.
  - Reads return `rdata = 0` with the normal rvalid pulse.
  - Writes are dropped.
- Writes (cursor only):
  - `mem_we = 1` and `mem_wdata = cur_wdata` in the grant cycle.
  - No rvalid is produced.
- Read data: `rdata` is `mem_rdata` in the rvalid cycle, or forced to 0 for out-of-range reads.
- Reset (asynchronous, any time):
  - All gnt, rvalid, `addr_err`, `mem_en` and `mem_we` go to 0.
  - `mem_addr`, `mem_wdata` and the counters go to 0.
  - In-flight reads are discarded and produce no rvalid after release.

## Timing
- Cycle N: eligible requests are sampled and the decision is registered.
- Cycle N+1: the winner's gnt is 1 for exactly one cycle, together with the registered `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` and `addr_err`.
- Cycle N+2: the matching rvalid is 1 for one cycle and `rdata` is valid.
- The pipeline is fully overlapped: throughput is one access per cycle total, and one per two cycles per requester.
- Rvalids of different requesters never overlap, because grants never do.
- First decision is made on the first rising edge after `reset_key` deasserts. Outputs are 0 until then.

## Configuration
- `MAP_ARB_STARVE_EN`
  - Defined: wait counters and promotion are present, as described in Operation.
  - Undefined: strict fixed priority VGA > robot > cursor. Counters are not synthesized, and STARVE_MAX is unused.

## Test plan
- Reset: hold `reset_key=0` with all reqs high -> every output is 0. Release, then at N+1 `vga_gnt=1`.
- Single read: `rob_req` at row 1/col 1, RAM holds 4'h3 at address 0 -> `rob_gnt` and `mem_en=1`, `mem_addr=0` at N+1; `rob_rvalid=1`, `rdata=3` at N+2.
- Priority: all three request at once (VGA row 2/col 3, robot row 5/col 5, cursor row 1/col 2) -> grants in the order VGA (addr 22), robot (addr 84), cursor (addr 1) on three consecutive cycles.
- Starvation (macro on): VGA and robot re-request every eligible cycle while the cursor holds a request -> `cur_gnt` within 17 cycles of `cur_req`. With the macro off, no `cur_gnt` occurs in 100 cycles.
- Out of range: robot row 11/col 5 -> `rob_gnt` and `addr_err` together, `mem_en=0`; next cycle `rob_rvalid=1`, `rdata=0`.
- Write then read: cursor write row 10/col 20, wdata 4'h7 -> `mem_we=1`, `mem_addr=199`, no `cur_rvalid`. A following cursor read of the same cell returns `rdata=7`.

Source files
------------

// File: rtl/map_port_arbiter.sv
// Purpose : arbitrates the single-port map RAM between VGA, robot and cursor requesters (VGA > robot > cursor).
// Latency : request sampled in cycle N, grant + RAM strobes in N+1, rvalid/rdata in N+2.
// Backpr. : none towards the RAM; a requester holds req/row/col/we/wdata until its one-cycle gnt pulse.
//
// Ports:
//   clock_50, reset_key (async, active-low)
//   {vga,rob,cur}_req/_row/_col   : 1-based cell requests; cur_we/cur_wdata for cursor writes
//   {vga,rob,cur}_gnt             : grant pulse, one cycle after the winning request is sampled
//   {vga,rob,cur}_rvalid, rdata   : read return one cycle after gnt (rdata forced to 0 when out of range)
//   addr_err                      : pulses with gnt for a row/col outside 1..ROWS / 1..COLS
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : single-port RAM, read data one cycle after mem_en
//
// Optional feature: define MAP_ARB_STARVE_EN to add robot/cursor wait counters; a counter
// reaching STARVE_MAX promotes its requester above VGA (robot wins if both are promoted).
module map_port_arbiter #(
    parameter int ROWS       = 10,
    parameter int COLS       = 20,
    parameter int ROW_W      = 4,
    parameter int COL_W      = 5,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 4,
    parameter int STARVE_MAX = 15
) (
    input  logic              clock_50,
    input  logic              reset_key,
    input  logic              vga_req,
    input  logic              rob_req,
    input  logic              cur_req,
    input  logic [ROW_W-1:0]  vga_row,
    input  logic [ROW_W-1:0]  rob_row,
    input  logic [ROW_W-1:0]  cur_row,
    input  logic [COL_W-1:0]  vga_col,
    input  logic [COL_W-1:0]  rob_col,
    input  logic [COL_W-1:0]  cur_col,
    input  logic              cur_we,
    input  logic [DATA_W-1:0] cur_wdata,
    output logic              vga_gnt,
    output logic              rob_gnt,
    output logic              cur_gnt,
    output logic              vga_rvalid,
    output logic              rob_rvalid,
    output logic              cur_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ROW_W-1:0]  L_ROWS   = ROW_W'(ROWS);
    localparam logic [COL_W-1:0]  L_COLS_C = COL_W'(COLS);
    localparam logic [ADDR_W-1:0] L_COLS_A = ADDR_W'(COLS);

    // Requester vectors are ordered {cursor, robot, vga}.
    logic [2:0]        r_gnt;
    logic [2:0]        r_rvld;
    logic              r_is_wr;     // the current grant is a cursor write (no read return)
    logic              r_rd_oor;    // the read being returned was out of range
    logic              r_addr_err;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [2:0]        w_elig;
    logic [2:0]        w_pick;
    logic              w_rob_prom;
    logic              w_cur_prom;
    logic [ROW_W-1:0]  w_row;
    logic [COL_W-1:0]  w_col;
    logic              w_in_range;
    logic              w_is_wr;
    logic              w_any;
    logic [ADDR_W-1:0] w_addr;

    // A requester whose gnt is showing this cycle is not eligible again until the next one.
    assign w_elig = {cur_req, rob_req, vga_req} & ~r_gnt;

    always_comb begin
        w_pick = 3'b000;
        if (w_rob_prom) begin
            w_pick = 3'b010;
        end else if (w_cur_prom) begin
            w_pick = 3'b100;
        end else if (w_elig[0]) begin
            w_pick = 3'b001;
        end else if (w_elig[1]) begin
            w_pick = 3'b010;
        end else if (w_elig[2]) begin
            w_pick = 3'b100;
        end
    end

    always_comb begin
        w_row = vga_row;
        w_col = vga_col;
        if (w_pick[1]) begin
            w_row = rob_row;
            w_col = rob_col;
        end else if (w_pick[2]) begin
            w_row = cur_row;
            w_col = cur_col;
        end
    end

    assign w_any      = |w_pick;
    assign w_is_wr    = w_pick[2] & cur_we;
    assign w_in_range = (w_row != '0) && (w_row <= L_ROWS) && (w_col != '0) && (w_col <= L_COLS_C);
    // Only meaningful when w_in_range; row/col are 1-based.
    assign w_addr     = (ADDR_W'(w_row) - ADDR_W'(1)) * L_COLS_A + ADDR_W'(w_col) - ADDR_W'(1);

`ifdef MAP_ARB_STARVE_EN
    localparam int              CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] L_SMAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_rob_wait;
    logic [CNT_W-1:0] r_cur_wait;

    assign w_rob_prom = w_elig[1] && (r_rob_wait == L_SMAX);
    assign w_cur_prom = w_elig[2] && (r_cur_wait == L_SMAX);

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            r_rob_wait <= '0;
            r_cur_wait <= '0;
        end else begin
            if (w_pick[1]) begin
                r_rob_wait <= '0;
            end else if (w_elig[1] && (r_rob_wait != L_SMAX)) begin
                r_rob_wait <= r_rob_wait + CNT_W'(1);
            end
            if (w_pick[2]) begin
                r_cur_wait <= '0;
            end else if (w_elig[2] && (r_cur_wait != L_SMAX)) begin
                r_cur_wait <= r_cur_wait + CNT_W'(1);
            end
        end
    end
`else
    logic w_unused_starve;
    assign w_unused_starve = (STARVE_MAX != 0);
    assign w_rob_prom      = 1'b0;
    assign w_cur_prom      = 1'b0;
`endif

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            r_gnt       <= '0;
            r_rvld      <= '0;
            r_is_wr     <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_addr_err  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            // Grant stage.
            r_gnt      <= w_pick;
            r_is_wr    <= w_is_wr;
            r_addr_err <= w_any & ~w_in_range;
            r_mem_en   <= w_any & w_in_range;
            r_mem_we   <= w_is_wr & w_in_range;
            // Address/data hold their last value while idle to avoid needless toggling.
            if (w_any && w_in_range) begin
                r_mem_addr <= w_addr;
            end
            if (w_is_wr && w_in_range) begin
                r_mem_wdata <= cur_wdata;
            end
            // Return stage: every granted read (in range or not) gets exactly one rvalid.
            r_rvld   <= r_gnt & ~{r_is_wr, 2'b00};
            r_rd_oor <= r_addr_err;
        end
    end

    assign vga_gnt    = r_gnt[0];
    assign rob_gnt    = r_gnt[1];
    assign cur_gnt    = r_gnt[2];
    assign vga_rvalid = r_rvld[0];
    assign rob_rvalid = r_rvld[1];
    assign cur_rvalid = r_rvld[2];
    assign addr_err   = r_addr_err;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    // RAM output is passed through only in a valid, in-range return cycle.
    assign rdata      = ((|r_rvld) && !r_rd_oor) ? mem_rdata : '0;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Purpose : randomized + directed check of map_port_arbiter against a cycle-level reference model.
// Latency : model predicts gnt one cycle after sampling and rvalid/rdata one cycle after gnt.
// Backpr. : bench requesters hold each request until their grant, then drop or re-request.
module tb_map_port_arbiter;
    localparam int ROWS = 10;
    localparam int COLS = 20;
    localparam int SMAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vga_req, rob_req, cur_req;
    logic [3:0] vga_row, rob_row, cur_row;
    logic [4:0] vga_col, rob_col, cur_col;
    logic       cur_we;
    logic [3:0] cur_wdata;
    logic       vga_gnt, rob_gnt, cur_gnt;
    logic       vga_rvalid, rob_rvalid, cur_rvalid;
    logic [3:0] rdata;
    logic       addr_err, mem_en, mem_we;
    logic [7:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata = 4'h0;

    always #5 clk = ~clk;

    map_port_arbiter #(
        .ROWS(10), .COLS(20), .ROW_W(4), .COL_W(5), .ADDR_W(8), .DATA_W(4), .STARVE_MAX(15)
    ) dut (
        .clock_50(clk), .reset_key(rst_n),
        .vga_req(vga_req), .rob_req(rob_req), .cur_req(cur_req),
        .vga_row(vga_row), .rob_row(rob_row), .cur_row(cur_row),
        .vga_col(vga_col), .rob_col(rob_col), .cur_col(cur_col),
        .cur_we(cur_we), .cur_wdata(cur_wdata),
        .vga_gnt(vga_gnt), .rob_gnt(rob_gnt), .cur_gnt(cur_gnt),
        .vga_rvalid(vga_rvalid), .rob_rvalid(rob_rvalid), .cur_rvalid(cur_rvalid),
        .rdata(rdata), .addr_err(addr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Environment RAM driven by the DUT, and the model's own copy of the map.
    logic [3:0] ram [0:255];
    logic [3:0] mdl [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: what the outputs must be in the current cycle.
    bit         model_on = 1'b0;
    logic [2:0] e_gnt, e_rv;
    logic       e_en, e_we, e_err, e_wr;
    logic [7:0] e_addr;
    logic [3:0] e_wd, e_rd, e_rdata;
    int         w_rob, w_cur;

    always @(negedge clk) begin
        logic [2:0] elig;
        int win, r, c;
        bit ok;
        if (!model_on) begin
            e_gnt = '0; e_rv = '0; e_en = 0; e_we = 0; e_err = 0; e_wr = 0;
            e_addr = '0; e_wd = '0; e_rd = '0; e_rdata = '0;
            w_rob = 0; w_cur = 0;
        end else begin
            chk("vga_gnt", vga_gnt, e_gnt[0]);
            chk("rob_gnt", rob_gnt, e_gnt[1]);
            chk("cur_gnt", cur_gnt, e_gnt[2]);
            chk("vga_rvalid", vga_rvalid, e_rv[0]);
            chk("rob_rvalid", rob_rvalid, e_rv[1]);
            chk("cur_rvalid", cur_rvalid, e_rv[2]);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            chk("addr_err", addr_err, e_err);
            if (e_en)  chk("mem_addr", mem_addr, e_addr);
            if (e_we)  chk("mem_wdata", mem_wdata, e_wd);
            if (|e_rv) chk("rdata", rdata, e_rdata);

            // Next decision, from the request lines as they stand for the coming edge.
            elig = {cur_req, rob_req, vga_req} & ~e_gnt;
            win = -1;
`ifdef MAP_ARB_STARVE_EN
            if (elig[1] && w_rob == SMAX)      win = 1;
            else if (elig[2] && w_cur == SMAX) win = 2;
`endif
            if (win < 0) begin
                if (elig[0])      win = 0;
                else if (elig[1]) win = 1;
                else if (elig[2]) win = 2;
            end
`ifdef MAP_ARB_STARVE_EN
            if (win == 1) w_rob = 0; else if (elig[1] && w_rob < SMAX) w_rob++;
            if (win == 2) w_cur = 0; else if (elig[2] && w_cur < SMAX) w_cur++;
`endif
            e_rv    = (|e_gnt && !e_wr) ? e_gnt : 3'b000;
            e_rdata = e_rd;
            e_gnt = '0; e_en = 0; e_we = 0; e_err = 0; e_wr = 0;
            if (win >= 0) begin
                e_gnt[win] = 1'b1;
                r = (win == 0) ? int'(vga_row) : (win == 1) ? int'(rob_row) : int'(cur_row);
                c = (win == 0) ? int'(vga_col) : (win == 1) ? int'(rob_col) : int'(cur_col);
                ok = (r >= 1 && r <= ROWS && c >= 1 && c <= COLS);
                e_err = !ok;
                e_wr  = (win == 2) && cur_we;
                e_rd  = 4'h0;
                if (ok) begin
                    e_addr = 8'((r - 1) * COLS + (c - 1));
                    e_en   = 1'b1;
                    e_we   = e_wr;
                    if (e_wr) begin
                        e_wd         = cur_wdata;
                        mdl[e_addr]  = cur_wdata;
                    end
                    e_rd = mdl[e_addr];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vga_req = 0; rob_req = 0; cur_req = 0; cur_we = 0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, {cur_gnt, rob_gnt, vga_gnt}, 0);
        chk({nm, "_rvalid"}, {cur_rvalid, rob_rvalid, vga_rvalid}, 0);
        chk({nm, "_strobes"}, {addr_err, mem_en, mem_we}, 0);
        chk({nm, "_addr"}, mem_addr, 0);
        chk({nm, "_wdata"}, mem_wdata, 0);
        chk({nm, "_rdata"}, rdata, 0);
    endtask

    initial begin
        logic [3:0] v;
        bit pend [3];
        int k;
        bit got;
        for (int i = 0; i < 256; i++) begin
            v = 4'($urandom);
            ram[i] = v;
            mdl[i] = v;
        end
        ram[0] = 4'h3;
        mdl[0] = 4'h3;

        // Reset with every request asserted.
        rst_n = 0;
        vga_req = 1; rob_req = 1; cur_req = 1; cur_we = 0; cur_wdata = 0;
        vga_row = 1; vga_col = 1; rob_row = 1; rob_col = 2; cur_row = 1; cur_col = 3;
        repeat (3) cyc();
        chk_zero("reset");
        rst_n = 1;
        model_on = 1;
        cyc();
        chk("reset_first_vga", vga_gnt, 1);
        idle();
        repeat (2) cyc();

        // Single read at row 1 / col 1.
        rob_req = 1; rob_row = 1; rob_col = 1;
        cyc();
        chk("rd_gnt", rob_gnt, 1);
        chk("rd_en", mem_en, 1);
        chk("rd_addr", mem_addr, 0);
        rob_req = 0;
        cyc();
        chk("rd_rvalid", rob_rvalid, 1);
        chk("rd_rdata", rdata, 4'h3);
        cyc();

        // Fixed priority.
        vga_req = 1; vga_row = 2; vga_col = 3;
        rob_req = 1; rob_row = 5; rob_col = 5;
        cur_req = 1; cur_row = 1; cur_col = 2; cur_we = 0;
        cyc();
        chk("pri_vga", {cur_gnt, rob_gnt, vga_gnt}, 3'b001);
        chk("pri_vga_addr", mem_addr, 22);
        vga_req = 0;
        cyc();
        chk("pri_rob", {cur_gnt, rob_gnt, vga_gnt}, 3'b010);
        chk("pri_rob_addr", mem_addr, 84);
        rob_req = 0;
        cyc();
        chk("pri_cur", {cur_gnt, rob_gnt, vga_gnt}, 3'b100);
        chk("pri_cur_addr", mem_addr, 1);
        cur_req = 0;
        repeat (2) cyc();

        // Out-of-range row.
        rob_req = 1; rob_row = 11; rob_col = 5;
        cyc();
        chk("oor_gnt_err", {rob_gnt, addr_err}, 2'b11);
        chk("oor_en", mem_en, 0);
        rob_req = 0;
        cyc();
        chk("oor_rvalid", rob_rvalid, 1);
        chk("oor_rdata", rdata, 0);
        cyc();

        // Write then read back the last cell.
        cur_req = 1; cur_row = 10; cur_col = 20; cur_we = 1; cur_wdata = 4'h7;
        cyc();
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 199);
        cur_we = 0;
        cyc();
        chk("wr_no_rvalid", cur_rvalid, 0);
        cyc();
        chk("rb_gnt", cur_gnt, 1);
        cur_req = 0;
        cyc();
        chk("rb_rvalid", cur_rvalid, 1);
        chk("rb_rdata", rdata, 4'h7);
        repeat (2) cyc();

        // Starvation: VGA and robot keep requesting while the cursor waits.
        vga_req = 1; vga_row = 3; vga_col = 3;
        rob_req = 1; rob_row = 4; rob_col = 4;
        cur_req = 1; cur_row = 6; cur_col = 6; cur_we = 0;
        k = 0;
        got = 0;
        while (k < 100 && !got) begin
            cyc();
            k++;
            if (cur_gnt) got = 1;
        end
`ifdef MAP_ARB_STARVE_EN
        chk("starve_gnt", got, 1);
        chk("starve_latency_ok", k <= 17, 1);
`else
        chk("starve_no_gnt", got, 0);
`endif
        idle();
        repeat (3) cyc();

        // Randomized traffic.
        for (int i = 0; i < 3; i++) pend[i] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i] && e_gnt[i]) begin
                    pend[i] = 0;
                    if (i == 0) vga_req = 0; else if (i == 1) rob_req = 0; else cur_req = 0;
                end
                if (!pend[i] && $urandom_range(0, (i == 0) ? 1 : 2) == 0) begin
                    pend[i] = 1;
                    if (i == 0) begin
                        vga_req = 1; vga_row = 4'($urandom_range(0, 11)); vga_col = 5'($urandom_range(0, 21));
                    end else if (i == 1) begin
                        rob_req = 1; rob_row = 4'($urandom_range(0, 11)); rob_col = 5'($urandom_range(0, 21));
                    end else begin
                        cur_req = 1; cur_row = 4'($urandom_range(0, 11)); cur_col = 5'($urandom_range(0, 21));
                        cur_we = 1'($urandom); cur_wdata = 4'($urandom);
                    end
                end
            end
            cyc();
        end

        // Reset in the middle of traffic: everything clears, nothing in flight returns.
        rst_n = 0;
        model_on = 0;
        #1;
        chk_zero("midrst");
        idle();
        cyc();
        rst_n = 1;
        model_on = 1;
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
